// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg: shared defaults and helpers for the tick generator.
package tick_gen_pkg;

  localparam int CNT_W_DEF    = 16;
  localparam int DIV_INIT_DEF = 19;  // 20 MHz / (19+1) = 1 MHz tick

  typedef logic [CNT_W_DEF-1:0] cnt_t;

  // Width of a channel index; never narrower than one bit.
  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tick_gen_ch.sv
// tick_gen_ch: one tick channel -- divider register, down-counter, tick flop.
// Optional single-step support is compiled in with TICK_GEN_STEP_EN.
module tick_gen_ch #(
  parameter int          CNT_W    = 16,
  parameter int unsigned DIV_INIT = 19
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_i,     // divider write targets this channel
  input  logic [CNT_W-1:0] wdata_i,
  input  logic             en_i,
  input  logic             sync_i,
`ifdef TICK_GEN_STEP_EN
  input  logic             step_i,
`endif
  output logic             tick_o
);

  localparam logic [CNT_W-1:0] INIT = CNT_W'(DIV_INIT);

  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic [CNT_W-1:0] div_eff;  // divider as seen by a reload this cycle

  // Next-state: sync beats counting; a reload always picks up a same-cycle write.
  always_comb begin
    div_eff = wr_i ? wdata_i : div_q;
    div_d   = div_eff;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    if (sync_i) begin
      cnt_d = div_eff;
    end else if (en_i) begin
      if (cnt_q == '0) begin
        tick_d = 1'b1;
        cnt_d  = div_eff;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end else begin
      // Disabled: counter frozen, except that a write preloads it.
      if (wr_i) cnt_d = wdata_i;
`ifdef TICK_GEN_STEP_EN
      if (step_i) tick_d = 1'b1;
`endif
    end
  end

  // State registers; reset reloads the default rate at any point in a period.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q  <= INIT;
      cnt_q  <= INIT;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/tick_gen.sv
// tick_gen: multi-channel clock-enable strobe generator on CLOCK_20.
// Define TICK_GEN_STEP_EN to add the step_req single-step port.
module tick_gen
  import tick_gen_pkg::*;
#(
  parameter int          NUM_CH   = 4,
  parameter int          CNT_W    = CNT_W_DEF,
  parameter int unsigned DIV_INIT = DIV_INIT_DEF,
  localparam int         CH_W     = ch_w(NUM_CH)
) (
  input  logic              CLOCK_20,
  input  logic              RESET_N,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync,
`ifdef TICK_GEN_STEP_EN
  input  logic [NUM_CH-1:0] step_req,
`endif
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] running
);

  logic [NUM_CH-1:0] wr_sel;
  logic [NUM_CH-1:0] running_q;

  // Write decode: indices with no matching channel select nothing, so
  // out-of-range writes are dropped.
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_we && (int'(cfg_ch) == i)) wr_sel[i] = 1'b1;
    end
  end

  // Registered copy of the channel enables.
  always_ff @(posedge CLOCK_20 or negedge RESET_N) begin
    if (!RESET_N) running_q <= '0;
    else          running_q <= ch_en;
  end

  assign running = running_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tick_gen_ch #(
      .CNT_W    (CNT_W),
      .DIV_INIT (DIV_INIT)
    ) u_ch (
      .clk_i   (CLOCK_20),
      .rst_ni  (RESET_N),
      .wr_i    (wr_sel[g]),
      .wdata_i (cfg_div),
      .en_i    (ch_en[g]),
      .sync_i  (sync),
`ifdef TICK_GEN_STEP_EN
      .step_i  (step_req[g]),
`endif
      .tick_o  (tick[g])
    );
  end

endmodule

// File: tb/tb_tick_gen.sv
// tb_tick_gen: directed, table-driven bench for tick_gen (4 channels).
module tb_tick_gen;

  logic        CLOCK_20 = 1'b0;
  logic        RESET_N;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_div;
  logic [3:0]  ch_en;
  logic        sync;
  logic [3:0]  step_req;
  logic [3:0]  tick;
  logic [3:0]  running;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        we;
    logic [1:0]  ch;
    logic [15:0] dv;
    logic [3:0]  en;
    logic        sy;
    logic [3:0]  st;
    logic [3:0]  exp_tick;
    logic [3:0]  exp_run;
  } vec_t;

  vec_t tbl [0:63];
  int   ntbl = 0;

  tick_gen dut (
    .CLOCK_20 (CLOCK_20),
    .RESET_N  (RESET_N),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .ch_en    (ch_en),
    .sync     (sync),
`ifdef TICK_GEN_STEP_EN
    .step_req (step_req),
`endif
    .tick     (tick),
    .running  (running)
  );

  always #5 CLOCK_20 = ~CLOCK_20;

  task automatic edge_wait();
    @(posedge CLOCK_20);
    #1;
  endtask

  task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic add(input logic we, input logic [1:0] ch, input logic [15:0] dv,
                     input logic [3:0] en, input logic sy, input logic [3:0] st,
                     input logic [3:0] et);
    tbl[ntbl] = '{we, ch, dv, en, sy, st, et, en};
    ntbl++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp;
    RESET_N = 1'b0; cfg_we = 1'b0; cfg_ch = 2'd0; cfg_div = 16'd0;
    ch_en = 4'b0000; sync = 1'b0; step_req = 4'b0000;
    repeat (3) edge_wait();
    check("reset_tick", tick, 4'b0000);
    check("reset_running", running, 4'b0000);

    // Channel 0 at the default rate, then a divider write at cnt=10 (edge 70).
    ch_en = 4'b0001; RESET_N = 1'b1;
    for (int n = 1; n <= 95; n++) begin
      cfg_we = (n == 70); cfg_ch = 2'd0; cfg_div = 16'd4;
      edge_wait();
      exp = (n == 20 || n == 40 || n == 60 || n == 80 || n == 85 || n == 90 || n == 95)
            ? 4'b0001 : 4'b0000;
      check($sformatf("run_tick_e%0d", n), tick, exp);
      check($sformatf("run_running_e%0d", n), running, 4'b0001);
    end
    cfg_we = 1'b0;

    // Asynchronous reset while tick is high, then restart from the default divider.
    #2 RESET_N = 1'b0;
    #1;
    check("async_reset_tick", tick, 4'b0000);
    check("async_reset_running", running, 4'b0000);
    edge_wait();
    RESET_N = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      edge_wait();
      exp = (n == 20) ? 4'b0001 : 4'b0000;
      check($sformatf("restart_tick_e%0d", n), tick, exp);
    end

    // Fresh reset for the table.
    ch_en = 4'b0000; RESET_N = 1'b0;
    edge_wait();
    RESET_N = 1'b1;

    //   we  ch     div     en       sy    step     exp_tick
    add(1, 2'd1, 16'd3, 4'b0000, 0, 4'b0000, 4'b0000);  // 0 ch1 div=3 (disabled)
    add(1, 2'd2, 16'd0, 4'b0000, 0, 4'b0000, 4'b0000);  // 1 ch2 div=0
    add(1, 2'd3, 16'd7, 4'b0000, 0, 4'b0000, 4'b0000);  // 2 ch3 div=7
    add(0, 2'd0, 16'd0, 4'b0010, 0, 4'b0000, 4'b0000);  // 3 enable ch1
    add(0, 2'd0, 16'd0, 4'b0010, 0, 4'b0000, 4'b0000);  // 4
    add(0, 2'd0, 16'd0, 4'b0010, 0, 4'b0000, 4'b0000);  // 5
    add(0, 2'd0, 16'd0, 4'b0010, 0, 4'b0000, 4'b0010);  // 6 first ch1 tick
    add(0, 2'd0, 16'd0, 4'b0010, 0, 4'b0000, 4'b0000);  // 7
    add(0, 2'd0, 16'd0, 4'b0010, 0, 4'b0000, 4'b0000);  // 8
    add(0, 2'd0, 16'd0, 4'b0010, 0, 4'b0000, 4'b0000);  // 9
    add(0, 2'd0, 16'd0, 4'b0010, 0, 4'b0000, 4'b0010);  // 10 period 4
    add(0, 2'd0, 16'd0, 4'b1111, 1, 4'b0000, 4'b0000);  // 11 sync, all on
    add(0, 2'd0, 16'd0, 4'b1111, 0, 4'b0000, 4'b0100);  // 12 ch2 every cycle
    add(0, 2'd0, 16'd0, 4'b1111, 0, 4'b0000, 4'b0100);  // 13
    add(0, 2'd0, 16'd0, 4'b1111, 0, 4'b0000, 4'b0100);  // 14
    add(0, 2'd0, 16'd0, 4'b1111, 0, 4'b0000, 4'b0110);  // 15 ch1 4 edges after sync
    add(0, 2'd0, 16'd0, 4'b1111, 0, 4'b0000, 4'b0100);  // 16
    add(0, 2'd0, 16'd0, 4'b1111, 0, 4'b0000, 4'b0100);  // 17
    add(0, 2'd0, 16'd0, 4'b1111, 0, 4'b0000, 4'b0100);  // 18
    add(0, 2'd0, 16'd0, 4'b1111, 0, 4'b0000, 4'b1110);  // 19 ch3 8 edges after sync
    add(0, 2'd0, 16'd0, 4'b0101, 0, 4'b0000, 4'b0100);  // 20 ch1/ch3 off
    add(1, 2'd1, 16'd5, 4'b0101, 0, 4'b0000, 4'b0100);  // 21 ch1 div=5 preload
    add(0, 2'd0, 16'd0, 4'b0111, 0, 4'b0000, 4'b0100);  // 22 ch1 on
    add(0, 2'd0, 16'd0, 4'b0111, 0, 4'b0000, 4'b0100);  // 23
    add(0, 2'd0, 16'd0, 4'b0111, 0, 4'b0000, 4'b0100);  // 24
    add(0, 2'd0, 16'd0, 4'b0111, 0, 4'b0000, 4'b0100);  // 25
    add(0, 2'd0, 16'd0, 4'b0111, 0, 4'b0000, 4'b0100);  // 26
    add(0, 2'd0, 16'd0, 4'b0111, 0, 4'b0000, 4'b0110);  // 27 ch1 tick, reload 5
    add(0, 2'd0, 16'd0, 4'b0101, 0, 4'b0000, 4'b0100);  // 28 ch1 frozen at 5
    add(0, 2'd0, 16'd0, 4'b0111, 0, 4'b0000, 4'b0100);  // 29 resume
    add(0, 2'd0, 16'd0, 4'b0111, 0, 4'b0000, 4'b0100);  // 30
    add(0, 2'd0, 16'd0, 4'b0111, 0, 4'b0000, 4'b0101);  // 31 ch0 tick
    add(0, 2'd0, 16'd0, 4'b0111, 0, 4'b0000, 4'b0100);  // 32
    add(0, 2'd0, 16'd0, 4'b0111, 0, 4'b0000, 4'b0100);  // 33
    add(0, 2'd0, 16'd0, 4'b0111, 0, 4'b0000, 4'b0110);  // 34 ch1 tick after resume
    add(1, 2'd3, 16'd2, 4'b1111, 1, 4'b0000, 4'b0000);  // 35 sync + ch3 div=2
    add(0, 2'd0, 16'd0, 4'b1111, 0, 4'b0000, 4'b0100);  // 36
    add(0, 2'd0, 16'd0, 4'b1111, 0, 4'b0000, 4'b0100);  // 37
    add(0, 2'd0, 16'd0, 4'b1111, 0, 4'b0000, 4'b1100);  // 38 ch3 uses new div
`ifdef TICK_GEN_STEP_EN
    add(0, 2'd0, 16'd0, 4'b0000, 0, 4'b1000, 4'b1000);  // 39 step ch3
    add(0, 2'd0, 16'd0, 4'b0000, 0, 4'b0000, 4'b0000);  // 40 single cycle only
    add(0, 2'd0, 16'd0, 4'b1000, 0, 4'b1000, 4'b0000);  // 41 step ignored enabled
    add(0, 2'd0, 16'd0, 4'b1000, 0, 4'b0000, 4'b0000);  // 42
    add(0, 2'd0, 16'd0, 4'b1000, 0, 4'b0000, 4'b1000);  // 43 cnt untouched by step
    add(0, 2'd0, 16'd0, 4'b0000, 1, 4'b1000, 4'b0000);  // 44 step ignored under sync
    add(0, 2'd0, 16'd0, 4'b0000, 0, 4'b0000, 4'b0000);  // 45
`endif

    for (int i = 0; i < ntbl; i++) begin
      cfg_we   = tbl[i].we;
      cfg_ch   = tbl[i].ch;
      cfg_div  = tbl[i].dv;
      ch_en    = tbl[i].en;
      sync     = tbl[i].sy;
      step_req = tbl[i].st;
      edge_wait();
      check($sformatf("vec%0d_tick", i), tick, tbl[i].exp_tick);
      check($sformatf("vec%0d_running", i), running, tbl[i].exp_run);
    end
    cfg_we = 1'b0; sync = 1'b0; step_req = 4'b0000; ch_en = 4'b0000;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tick_gen.md
# tick_gen

Parametrised multi-channel tick generator for the board-level CPU top, running on CLOCK_20 and producing single-cycle enable strobes (tick) at per-channel programmable rates. It replaces ad-hoc free-running clock dividers: all downstream logic stays on CLOCK_20 and uses tick as a clock enable. Dividers are runtime-writable, channels are individually enabled, and a global sync realigns all channels.

## Interface
- NUM_CH, 4, number of independent channels (1..16)
- CNT_W, 16, divider/counter width in bits
- DIV_INIT, 19, divider and counter reset value (20 MHz / 20 = 1 MHz tick)
- CH_W, derived max(1,$clog2(NUM_CH)), width of cfg_ch

- CLOCK_20  in  1  system clock, all logic rising-edge
- RESET_N  in  1  asynchronous active-low reset
- cfg_we  in  1  divider write strobe
- cfg_ch  in  CH_W  channel index for the write
- cfg_div  in  CNT_W  new divider value; period = cfg_div+1 cycles
- ch_en  in  NUM_CH  per-channel run enable (level)
- sync  in  1  reload all counters from their dividers
- step_req  in  NUM_CH  single-step request (present only with TICK_GEN_STEP_EN)
- tick  out  NUM_CH  registered one-cycle strobe per channel
- running  out  NUM_CH  registered copy of ch_en

## Operation
- Per channel: div register (CNT_W), down-counter cnt (CNT_W), tick flop.
- Each edge, per channel i, priority order:
  - sync=1: cnt<=div (the new cfg_div if cfg_we targets i this cycle); tick<=0.
  - ch_en[i]=1 and cnt==0: tick<=1; cnt<=div (new value if written this cycle).
  - ch_en[i]=1, cnt!=0: cnt<=cnt-1; tick<=0.
  - ch_en[i]=0: cnt holds; tick<=0; if cfg_we targets i, cnt<=cfg_div as well.
- Divider write to a running channel takes effect at the next reload; the current period completes unchanged (no short/long glitch period).
- div=0: tick high every cycle while enabled.
- Disable freezes cnt; re-enable resumes from the frozen value.
- cfg_ch >= NUM_CH: write ignored.
- Reset (any time, including mid-period): div=DIV_INIT, cnt=DIV_INIT, tick=0, running=0.

## Timing
- tick and running are flop outputs; no combinational input-to-output path.
- Enable asserted at edge k with cnt=c: first tick high in the cycle after edge k+c+1 (c+1 edges of counting, tick registered on the last).
- Steady state: tick period exactly div+1 cycles, high width exactly 1 cycle.
- sync at edge k: no tick from edge k; first tick div+1 edges later for all enabled channels simultaneously.
- Divider write latency: 1 cycle into div; effective at next reload.

## Configuration
- TICK_GEN_STEP_EN defined: step_req port exists; step_req[i]=1 while ch_en[i]=0 gives tick[i]=1 for exactly one cycle one edge later, cnt unchanged; step_req ignored while enabled or while sync=1.
- Not defined: no step_req port, no step logic; tick only from counting.

## Structure
- Package tick_gen_pkg: DIV_INIT default, CNT_W default, cnt_t typedef, helper for CH_W.
- Sub-module tick_gen_ch: one channel (div, cnt, tick, step), instantiated NUM_CH times via generate; top holds cfg decode, sync fan-out and running register.

## Test plan
- Reset then ch_en=4'b0001 held -> tick[0] first high after 20 edges, then every 20 cycles; tick[3:1]=0; running=4'b0001.
- Write cfg_ch=1, cfg_div=3 while ch1 disabled, then enable -> tick[1] high after 4 edges, period 4.
- Ch0 running div=19, write cfg_div=4 mid-period (cnt=10) -> next tick at the original position, then period 5.
- All four enabled with divs 19/3/0/7, pulse sync -> no ticks that cycle; ch2 ticks every cycle from next edge; ch1 and ch3 first ticks 4 and 8 edges after sync.
- RESET_N low mid-period with tick high -> tick=0, running=0 immediately; after release counters restart from 19.
- With TICK_GEN_STEP_EN: ch3 disabled, step_req[3] pulse -> tick[3] high exactly 1 cycle; step_req[3] with ch3 enabled -> no extra tick.
